// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is time-multiplexed over WIDTH clocks with a registered
// borrow. The result registers update only on the final bit-step and hold otherwise.
module serial_ripple_borrow_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow_Out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             done_q, done_d;

  logic bit_a, bit_b, bit_d, bit_bo;
  logic accept, running, last_step;

  // Full-subtractor cell on the current LSBs and the carried borrow
  always_comb begin
    bit_a  = a_sr_q[0];
    bit_b  = b_sr_q[0];
    bit_d  = bit_a ^ bit_b ^ brw_q;
    bit_bo = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);
  end

  // Handshake decode: start is only honoured while idle
  always_comb begin
    accept    = (state_q == StIdle) && start;
    running   = (state_q == StRun);
    last_step = running && (cnt_q == LastStep);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)    state_d = StRun;
      StRun:  if (last_step) state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // FSM outputs: busy covers exactly the WIDTH bit-step cycles
  always_comb begin
    busy = (state_q == StRun);
  end

  // Datapath next-state: load on accept, shift one bit per run cycle
  always_comb begin
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    d_sr_d       = d_sr_q;
    brw_d        = brw_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    done_d       = 1'b0;
    if (accept) begin
      a_sr_d = A;
      b_sr_d = B;
      brw_d  = Bin;
      d_sr_d = '0;
      cnt_d  = '0;
    end else if (running) begin
      a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
      d_sr_d = {bit_d, d_sr_q[WIDTH-1:1]};
      brw_d  = bit_bo;
      cnt_d  = cnt_q + CNT_W'(1);
      if (last_step) begin
        // The final difference bit lands in the MSB together with the shifted history
        diff_d       = {bit_d, d_sr_q[WIDTH-1:1]};
        borrow_out_d = bit_bo;
        done_d       = 1'b1;
      end
    end
  end

  // Datapath and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      d_sr_q       <= '0;
      brw_q        <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      d_sr_q       <= d_sr_d;
      brw_q        <= brw_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      done_q       <= done_d;
    end
  end

  // Registered results drive the outputs directly
  always_comb begin
    Diff       = diff_q;
    Borrow_Out = borrow_out_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Self-checking bench for serial_ripple_borrow_subtractor at WIDTH 4, 16 and 2.
// Expected results are queued when an operation is launched and popped on done.
module tb_serial_ripple_borrow_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        bo;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        start4, bin4, bo4, busy4, done4;
  logic [3:0]  a4, b4, diff4;
  logic        start16, bin16, bo16, busy16, done16;
  logic [15:0] a16, b16, diff16;
  logic        start2, bin2, bo2, busy2, done2;
  logic [1:0]  a2, b2, diff2;

  exp_t q4[$];
  exp_t q16[$];
  exp_t q2[$];
  exp_t e4, e16, e2;

  int n_cmp;
  int n_err;
  int cyc;

  serial_ripple_borrow_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Bin(bin4),
    .Diff(diff4), .Borrow_Out(bo4), .busy(busy4), .done(done4)
  );

  serial_ripple_borrow_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .Bin(bin16),
    .Diff(diff16), .Borrow_Out(bo16), .busy(busy16), .done(done16)
  );

  serial_ripple_borrow_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Bin(bin2),
    .Diff(diff2), .Borrow_Out(bo2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed integer subtraction, wrapped to w bits; negative means borrow
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bin);
    int   mask;
    int   s;
    exp_t e;
    mask   = (1 << w) - 1;
    s      = int'(a) - int'(b) - int'(bin);
    e.diff = 16'(s & mask);
    e.bo   = (s < 0);
    return e;
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      4:       return busy4;
      16:      return busy16;
      default: return busy2;
    endcase
  endfunction

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (busy_of(w) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("busy_timeout", 32'd1, 32'd0);
  endtask

  // Launch one op on DUT w at a negedge; returns at the negedge after the accept edge
  task automatic drive(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic bin);
    logic [15:0] mask;
    logic [15:0] at, bt;
    wait_idle(w);
    mask = 16'((32'd1 << w) - 1);
    at   = a & mask;
    bt   = b & mask;
    case (w)
      4:       begin a4 = at[3:0]; b4 = bt[3:0]; bin4 = bin; start4 = 1'b1;
                     q4.push_back(model(4, at, bt, bin)); end
      16:      begin a16 = at; b16 = bt; bin16 = bin; start16 = 1'b1;
                     q16.push_back(model(16, at, bt, bin)); end
      default: begin a2 = at[1:0]; b2 = bt[1:0]; bin2 = bin; start2 = 1'b1;
                     q2.push_back(model(2, at, bt, bin)); end
    endcase
    @(negedge clk);
    start4  = 1'b0;
    start16 = 1'b0;
    start2  = 1'b0;
  endtask

  task automatic expect_done4(input logic [3:0] d, input logic bo);
    int n;
    n = 0;
    while (!done4 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      check("done4_timeout", 32'd0, 32'd1);
    end else begin
      check("diff4_const", 32'(diff4), 32'(d));
      check("bo4_const", 32'(bo4), 32'(bo));
    end
  endtask

  // Scoreboard monitors: every done must match the oldest launched op
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        check("diff4", 32'(diff4), 32'(e4.diff[3:0]));
        check("bo4", 32'(bo4), 32'(e4.bo));
      end
      check("busy4_in_done", 32'(busy4), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        check("done16_unexpected", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        check("diff16", 32'(diff16), 32'(e16.diff));
        check("bo16", 32'(bo16), 32'(e16.bo));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        check("done2_unexpected", 32'd1, 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("diff2", 32'(diff2), 32'(e2.diff[1:0]));
        check("bo2", 32'(bo2), 32'(e2.bo));
      end
    end
  end

  initial begin
    int last;
    int n;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_diff", 32'(diff4), 32'd0);
    check("rst_bo", 32'(bo4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy4), 32'd0);

    // Test 1: latency and busy/done timing, 9 - 5
    drive(4, 16'd9, 16'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t1_busy", 32'(busy4), 32'd1);
      check("t1_no_done", 32'(done4), 32'd0);
      @(negedge clk);
    end
    check("t1_done", 32'(done4), 32'd1);
    check("t1_busy_end", 32'(busy4), 32'd0);
    check("t1_diff", 32'(diff4), 32'h4);
    check("t1_bo", 32'(bo4), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done4), 32'd0);
    check("t1_hold", 32'(diff4), 32'h4);

    // Test 2: borrow cases
    drive(4, 16'd5, 16'd9, 1'b0);
    expect_done4(4'hC, 1'b1);
    drive(4, 16'd0, 16'd0, 1'b1);
    expect_done4(4'hF, 1'b1);
    drive(4, 16'd0, 16'hF, 1'b1);
    expect_done4(4'h0, 1'b1);

    // Test 3: start held high, operands scrambled while busy
    wait_idle(4);
    start4 = 1'b1;
    last   = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (busy4 && n < 64) begin
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        @(negedge clk);
        n++;
      end
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      q4.push_back(model(4, 16'(a4), 16'(b4), bin4));
      if (k > 0) check("t3_period", 32'(cyc - last), 32'd5);
      last = cyc;
      @(negedge clk);
    end
    start4 = 1'b0;
    wait_idle(4);
    @(negedge clk);

    // Test 4: asynchronous reset mid-operation
    a4 = 4'hF; b4 = 4'h1; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_diff", 32'(diff4), 32'd0);
    check("t4_rst_bo", 32'(bo4), 32'd0);
    check("t4_rst_busy", 32'(busy4), 32'd0);
    check("t4_rst_done", 32'(done4), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_no_done", 32'(done4), 32'd0);
    end
    drive(4, 16'd3, 16'd1, 1'b0);
    expect_done4(4'h2, 1'b0);

    // Test 5: exhaustive at WIDTH 4, random at WIDTH 16 and 2
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          drive(4, 16'(a), 16'(b), 1'(c));
    for (int i = 0; i < 1500; i++)
      drive(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drive(16, 16'h0000, 16'hFFFF, 1'b1);
    for (int i = 0; i < 2000; i++)
      drive(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    wait_idle(4);
    wait_idle(16);
    wait_idle(2);
    repeat (4) @(negedge clk);
    check("q4_left", 32'(q4.size()), 32'd0);
    check("q16_left", 32'(q16.size()), 32'd0);
    check("q2_left", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
